osd_cmd_sequencer: RTL and testbench

- Upstream feeder for the OSD overlay block.
- Takes 16-bit command and data words from the host-side command FIFO through a valid/ready stream with a last flag.
- Serialises each packet into the OSD's framed strobe bus: io_osd is held high for the whole packet, io_strobe gets one pulse per word, and io_din is held stable around each pulse.
- Guarantees the timing the OSD needs: a clean strobe rising edge per word, and io_osd low between packets so that enable/disable commands commit.

---
 rtl/osd_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_osd_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_cmd_sequencer.sv
// osd_cmd_sequencer
//   Upstream feeder for the OSD overlay block. Accepts 16-bit command/data
//   words from the host command FIFO over a valid/ready stream and
//   serialises each packet onto the OSD framed strobe bus. io_osd frames the
//   whole packet. io_strobe pulses once per word. io_din is held stable from
//   the setup phase until the next accepted word.
//
// Ports
//   clk_sys    in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   s_valid    in   1   host word valid
//   s_ready    out  1   word accepted on this edge when s_valid is also high
//   s_data     in  16   host word (first word carries the command in [7:0])
//   s_last     in   1   final word of the packet
//   io_osd     out  1   OSD transaction frame
//   io_strobe  out  1   per-word strobe, OSD samples on its rising edge
//   io_din     out 16   word presented to the OSD
//   busy       out  1   sequencer is not idle
//   done       out  1   one-cycle pulse on normal packet completion
//   timeout    out  1   one-cycle pulse when a stalled packet is aborted
module osd_cmd_sequencer #(
  parameter int SETUP_CYC   = 1,
  parameter int STB_HI_CYC  = 2,
  parameter int STB_LO_CYC  = 2,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam int MAX_A   = (SETUP_CYC  > STB_HI_CYC) ? SETUP_CYC  : STB_HI_CYC;
  localparam int MAX_B   = (STB_LO_CYC > GAP_CYC)    ? STB_LO_CYC : GAP_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HI_END    = CNT_W'(STB_HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_END    = CNT_W'(STB_LO_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STB_HI = 3'd2;
  localparam logic [2:0] S_STB_LO = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_q;
  logic             accept;

  // s_ready is the registered decode of IDLE/WAIT, so the handshake only
  // ever completes in those two states.
  assign accept = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETUP;
      S_SETUP:  if (cnt == SETUP_END) state_nxt = S_STB_HI;
      S_STB_HI: if (cnt == HI_END) state_nxt = S_STB_LO;
      S_STB_LO: if (cnt == LO_END) state_nxt = last_q ? S_GAP : S_WAIT;
      // An accept on the same edge as the timeout takes priority.
      S_WAIT: begin
        if (accept)              state_nxt = S_SETUP;
        else if (cnt == TO_END)  state_nxt = S_GAP;
      end
      S_GAP:    if (cnt == GAP_END) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Every output is registered from the next-state decode so that it
  // changes on the same edge as the state it belongs to.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_q    <= 1'b0;
      s_ready   <= 1'b0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // The counter reloads on every state entry and idles at zero.
      cnt       <= ((state_nxt != state) || (state_nxt == S_IDLE)) ? '0 : cnt + 1'b1;
      s_ready   <= (state_nxt == S_IDLE) || (state_nxt == S_WAIT);
      busy      <= (state_nxt != S_IDLE);
      io_osd    <= state_nxt inside {S_SETUP, S_STB_HI, S_STB_LO, S_WAIT};
      io_strobe <= (state_nxt == S_STB_HI);
      done      <= (state == S_STB_LO) && (state_nxt == S_GAP);
      timeout   <= (state == S_WAIT) && (state_nxt == S_GAP);
      if (accept) begin
        io_din <= s_data;
        last_q <= s_last;
      end
    end
  end

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
module tb_osd_cmd_sequencer;

  localparam int K_STB  = 0;
  localparam int K_DONE = 1;
  localparam int K_TO   = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } ev_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic [15:0] s_data  = 16'h0000;
  logic        sel_t   = 1'b0;

  logic        v0, v1;
  logic        rdy0, osd0, stb0, busy0, done0, to0;
  logic        rdy1, osd1, stb1, busy1, done1, to1;
  logic [15:0] din0, din1;

  logic        m_rdy, m_osd, m_stb, m_busy, m_done, m_to;
  logic [15:0] m_din;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  ev_t exp_q[$];

  int  last_osd_run = 0;
  int  last_stb_run = 0;
  int  last_rises   = 0;
  int  stb_no_osd   = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  assign v0 = s_valid & ~sel_t;
  assign v1 = s_valid & sel_t;

  assign m_rdy  = sel_t ? rdy1  : rdy0;
  assign m_osd  = sel_t ? osd1  : osd0;
  assign m_stb  = sel_t ? stb1  : stb0;
  assign m_din  = sel_t ? din1  : din0;
  assign m_busy = sel_t ? busy1 : busy0;
  assign m_done = sel_t ? done1 : done0;
  assign m_to   = sel_t ? to1   : to0;

  osd_cmd_sequencer dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .s_valid  (v0),
    .s_ready  (rdy0),
    .s_data   (s_data),
    .s_last   (s_last),
    .io_osd   (osd0),
    .io_strobe(stb0),
    .io_din   (din0),
    .busy     (busy0),
    .done     (done0),
    .timeout  (to0)
  );

  osd_cmd_sequencer #(.TIMEOUT_CYC(16)) dut_to (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .s_valid  (v1),
    .s_ready  (rdy1),
    .s_data   (s_data),
    .s_last   (s_last),
    .io_osd   (osd1),
    .io_strobe(stb1),
    .io_din   (din1),
    .busy     (busy1),
    .done     (done1),
    .timeout  (to1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [15:0] din);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected event kind=%0d din=%0h with empty queue", kind, din);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (e.kind == K_STB) chk("sb_din_at_rise", {16'h0, din}, {16'h0, e.data});
    end
  endtask

  // Monitor: pops the scoreboard on every strobe rise, done and timeout.
  initial begin
    bit prev_stb;
    int osd_run, stb_run, rises;
    prev_stb = 0; osd_run = 0; stb_run = 0; rises = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_stb = 0; osd_run = 0; stb_run = 0; rises = 0;
        continue;
      end
      if (m_stb && !m_osd) stb_no_osd++;
      if (m_stb && !prev_stb) begin
        rises++;
        sb_pop(K_STB, m_din);
      end
      if (m_done) sb_pop(K_DONE, 16'h0);
      if (m_to)   sb_pop(K_TO, 16'h0);
      if (m_osd) osd_run++;
      else if (osd_run != 0) begin
        last_osd_run = osd_run;
        last_rises   = rises;
        osd_run      = 0;
        rises        = 0;
      end
      if (m_stb) stb_run++;
      else if (stb_run != 0) begin
        last_stb_run = stb_run;
        stb_run      = 0;
      end
      prev_stb = m_stb;
    end
  end

  task automatic send_word(input logic [15:0] d, input logic lst, input logic exp_done,
                           output int acc_cyc);
    int n;
    n = 0;
    exp_q.push_back(ev_t'{K_STB, d});
    if (exp_done) exp_q.push_back(ev_t'{K_DONE, 16'h0});
    s_data  = d;
    s_last  = lst;
    s_valid = 1'b1;
    while (!m_rdy && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    if (!m_rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_wait word=%0h not accepted within %0d cycles", d, n);
    end else begin
      @(posedge clk_sys);
      #1;
    end
    acc_cyc = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // which: 0 done, 1 timeout, 2 strobe, 3 s_ready
  task automatic wait_flag(input int which, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < 2000) begin
      @(negedge clk_sys);
      n++;
      case (which)
        0:       hit = m_done;
        1:       hit = m_to;
        2:       hit = m_stb;
        default: hit = m_rdy;
      endcase
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL %s event not seen after %0d cycles", name, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, t, viol;

    // Reset held with s_valid asserted.
    s_valid = 1'b1;
    s_data  = 16'h0041;
    repeat (3) @(negedge clk_sys);
    chk("rst_osd",    m_osd,   0);
    chk("rst_strobe", m_stb,   0);
    chk("rst_din",    m_din,   0);
    chk("rst_ready",  m_rdy,   0);
    chk("rst_busy",   m_busy,  0);
    chk("rst_done",   m_done,  0);
    chk("rst_timeout", m_to,   0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("ready_after_release", m_rdy, 1);

    // Three-word packet, continuous valid: 17 frame cycles, 3 strobes,
    // 2 gap cycles, next accept 20 edges after the first.
    send_word(16'h0041, 1'b0, 1'b0, a0);
    send_word(16'h0010, 1'b0, 1'b0, t);
    send_word(16'h0020, 1'b1, 1'b1, t);
    wait_flag(0, "pkt3_done");
    chk("pkt3_gap1_osd", m_osd, 0);
    @(negedge clk_sys);
    chk("pkt3_gap2_osd", m_osd, 0);
    chk("pkt3_gap2_ready", m_rdy, 0);
    @(negedge clk_sys);
    chk("pkt3_idle_ready", m_rdy, 1);
    chk("pkt3_next_accept_edge", cyc + 1 - a0, 20);
    chk("pkt3_osd_cycles", last_osd_run, 17);
    chk("pkt3_strobe_rises", last_rises, 3);

    // Single-word packet.
    send_word(16'h0040, 1'b1, 1'b1, a0);
    wait_flag(0, "single_done");
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("single_idle_ready", m_rdy, 1);
    chk("single_next_accept_edge", cyc + 1 - a0, 8);
    chk("single_osd_cycles", last_osd_run, 5);
    chk("single_strobe_width", last_stb_run, 2);
    chk("single_strobe_rises", last_rises, 1);

    // Host stall of 500 cycles inside a two-word packet.
    send_word(16'h0042, 1'b0, 1'b0, a0);
    wait_flag(3, "stall_wait_entry");
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_sys);
      if (!m_osd || m_stb || !m_rdy || m_to) viol++;
    end
    chk("stall_hold_violations", viol, 0);
    send_word(16'h00AA, 1'b1, 1'b1, t);
    wait_flag(0, "stall_done");
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("stall_idle_ready", m_rdy, 1);
    chk("stall_strobe_rises", last_rises, 2);

    // Timeout on the TIMEOUT_CYC=16 instance: WAIT entered 5 edges after
    // the accept, timeout 16 edges later.
    sel_t = 1'b1;
    send_word(16'h0043, 1'b0, 1'b0, a0);
    exp_q.push_back(ev_t'{K_TO, 16'h0});
    wait_flag(1, "to_pulse");
    chk("to_latency", cyc - a0, 21);
    @(negedge clk_sys);
    chk("to_osd_low", m_osd, 0);
    chk("to_single_pulse", m_to, 0);
    @(negedge clk_sys);
    chk("to_idle_ready", m_rdy, 1);
    sel_t = 1'b0;

    // Asynchronous reset while the strobe is high.
    send_word(16'h0044, 1'b0, 1'b0, t);
    wait_flag(2, "arst_strobe");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_osd",    m_osd,  0);
    chk("arst_strobe", m_stb,  0);
    chk("arst_busy",   m_busy, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    send_word(16'h0045, 1'b1, 1'b1, a0);
    wait_flag(0, "arst_recover_done");
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("arst_recover_ready", m_rdy, 1);
    chk("arst_recover_rises", last_rises, 1);

    repeat (3) @(negedge clk_sys);
    chk("sb_leftover", exp_q.size(), 0);
    chk("strobe_without_osd", stb_no_osd, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
